// File: rtl/npem_pkg.sv
// npem_pkg: shared state type and register bit positions for the NPEM slot controller.
package npem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} slot_state_e;

    localparam int EN     = 0;
    localparam int RST    = 1;
    localparam int CTL_LO = 2;
    localparam int CTL_HI = 11;
    localparam int ES_LO  = 24;
    localparam int IRQEN  = 30;

    localparam int CC   = 0;
    localparam int TO   = 1;
    localparam int BUSY = 2;
endpackage

// File: rtl/npem_slot_fsm.sv
// npem_slot_fsm: one slot's capability-masked Control/Status registers, command FSM and timeout counter.
module npem_slot_fsm
    import npem_pkg::*;
#(
    parameter int REG_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ctrl_i,
    input  logic             wr_stat_i,
    input  logic [REG_W-1:0] wdata_i,
    input  logic [REG_W-1:0] cap_i,
    input  logic             issued_i,
    input  logic             done_i,
    output logic             req_o,
    output logic             busy_hit_o,
    output logic             irq_o,
    output logic             cmd_reset_o,
    output logic [REG_W-1:0] ctrl_o,
    output logic [REG_W-1:0] stat_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    slot_state_e      state_q;
    logic [REG_W-1:0] ctrl_q, ctrl_d, ctrl_wr;
    logic [2:0]       stat_q, stat_d, stat_set, stat_clr;
    logic [TW-1:0]    timer_q;
    logic             rst_cmd_q, expire, finish;
    logic             unused_bits;

    assign unused_bits = ^{cap_i[23:12], cap_i[EN], wdata_i[23:12]};

    // done and timer expiry in the same cycle count as a plain completion
    assign finish     = (state_q == WAIT) && (done_i || timer_q == TW'(1));
    assign expire     = (state_q == WAIT) && !done_i && timer_q == TW'(1);
    assign busy_hit_o = wr_ctrl_i && (state_q != IDLE);

    assign ctrl_wr = {(|cap_i[31:ES_LO]) ? wdata_i[31:ES_LO] : ctrl_q[31:ES_LO], 12'b0,
                      wdata_i[CTL_HI:CTL_LO] & cap_i[CTL_HI:CTL_LO], 1'b0, wdata_i[EN]};
    assign ctrl_d  = (wr_ctrl_i && state_q == IDLE) ? ctrl_wr :
                     (finish && rst_cmd_q) ? {ctrl_q[31:12], 12'b0} : ctrl_q;

    assign stat_set = {busy_hit_o, expire, finish};
    assign stat_clr = wr_stat_i ? wdata_i[BUSY:CC] : 3'b0;
    assign stat_d   = (stat_q & ~stat_clr) | stat_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            stat_q    <= '0;
            timer_q   <= '0;
            rst_cmd_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            stat_q <= stat_d;
            case (state_q)
                IDLE: if (wr_ctrl_i) begin
                    state_q   <= REQ;
                    rst_cmd_q <= wdata_i[RST] & cap_i[RST];
                end
                REQ: if (issued_i) begin
                    state_q <= WAIT;
                    timer_q <= TW'(TIMEOUT_CYC);
                end
                WAIT: begin
                    timer_q <= timer_q - TW'(1);
                    if (finish) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o       = state_q == REQ;
    assign cmd_reset_o = rst_cmd_q;
    assign irq_o       = (stat_q[CC] | stat_q[TO]) & ctrl_q[IRQEN];
    assign ctrl_o      = ctrl_q;
    assign stat_o      = {{(REG_W-3){1'b0}}, stat_q};
endmodule

// File: rtl/npem_multi_slot_ctrl.sv
// npem_multi_slot_ctrl: multi-slot NPEM control/status engine with a round-robin
// arbiter feeding one shared enclosure backend through a registered command port.
module npem_multi_slot_ctrl
    import npem_pkg::*;
#(
    parameter int  NUM_SLOTS   = 4,
    parameter int  REG_W       = 32,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr_en_i,
    input  logic                       cfg_wr_sel_i,
    input  logic [SLOT_W-1:0]          cfg_slot_i,
    input  logic [REG_W-1:0]           cfg_wdata_i,
    output logic [REG_W-1:0]           cfg_rd_ctrl_o,
    output logic [REG_W-1:0]           cfg_rd_stat_o,
    output logic                       cfg_wr_busy_err_o,
    input  logic [NUM_SLOTS*REG_W-1:0] cap_i,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic [SLOT_W-1:0]          cmd_slot_o,
    output logic                       cmd_reset_o,
    output logic [REG_W-1:0]           cmd_data_o,
    input  logic                       cmd_done_i,
    input  logic [SLOT_W-1:0]          cmd_done_slot_i,
    output logic                       irq_o
);
    logic [NUM_SLOTS-1:0] wr_ctrl, wr_stat, issued, done, req, req_eff, busy_hit, irq_vec, rst_vec;
    logic [REG_W-1:0]     ctrl_v [NUM_SLOTS];
    logic [REG_W-1:0]     stat_v [NUM_SLOTS];
    logic [SLOT_W-1:0]    ptr_q, ptr_d, gnt, idx, cmd_slot_q;
    logic [REG_W-1:0]     cmd_data_q;
    logic                 slot_ok, hs, gnt_found, cmd_valid_q, cmd_reset_q, busy_err_q;

    assign slot_ok = 32'(cfg_slot_i) < 32'(NUM_SLOTS);
    assign hs      = cmd_valid_q && cmd_ready_i;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic sel;
        assign sel        = cfg_wr_en_i && slot_ok && 32'(cfg_slot_i) == 32'(i);
        assign wr_ctrl[i] = sel && !cfg_wr_sel_i;
        assign wr_stat[i] = sel && cfg_wr_sel_i;
        assign issued[i]  = hs && 32'(cmd_slot_q) == 32'(i);
        assign done[i]    = cmd_done_i && 32'(cmd_done_slot_i) == 32'(i);

        npem_slot_fsm #(
            .REG_W      (REG_W),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_ctrl_i  (wr_ctrl[i]),
            .wr_stat_i  (wr_stat[i]),
            .wdata_i    (cfg_wdata_i),
            .cap_i      (cap_i[i*REG_W +: REG_W]),
            .issued_i   (issued[i]),
            .done_i     (done[i]),
            .req_o      (req[i]),
            .busy_hit_o (busy_hit[i]),
            .irq_o      (irq_vec[i]),
            .cmd_reset_o(rst_vec[i]),
            .ctrl_o     (ctrl_v[i]),
            .stat_o     (stat_v[i])
        );
    end

    // the slot handshaking this cycle is still in REQ, so keep it out of the next pick
    assign req_eff = req & ~issued;
    assign ptr_d   = !hs ? ptr_q :
                     (32'(cmd_slot_q) + 32'd1 == 32'(NUM_SLOTS)) ? '0 : cmd_slot_q + SLOT_W'(1);

    always_comb begin
        gnt_found = 1'b0;
        gnt       = ptr_d;
        idx       = ptr_d;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            idx = SLOT_W'((32'(ptr_d) + 32'(k)) % 32'(NUM_SLOTS));
            if (req_eff[idx]) begin
                gnt_found = 1'b1;
                gnt       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_slot_q  <= '0;
            cmd_data_q  <= '0;
            cmd_reset_q <= 1'b0;
            ptr_q       <= '0;
            busy_err_q  <= 1'b0;
        end else begin
            busy_err_q <= |busy_hit;
            ptr_q      <= ptr_d;
            if (!cmd_valid_q || cmd_ready_i) begin
                cmd_valid_q <= gnt_found;
                cmd_slot_q  <= gnt;
                cmd_data_q  <= ctrl_v[gnt];
                cmd_reset_q <= rst_vec[gnt];
            end
        end
    end

    assign cfg_rd_ctrl_o     = slot_ok ? ctrl_v[cfg_slot_i] : '0;
    assign cfg_rd_stat_o     = slot_ok ? stat_v[cfg_slot_i] : '0;
    assign cfg_wr_busy_err_o = busy_err_q;
    assign cmd_valid_o       = cmd_valid_q;
    assign cmd_slot_o        = cmd_slot_q;
    assign cmd_reset_o       = cmd_reset_q;
    assign cmd_data_o        = cmd_data_q;
    assign irq_o             = |irq_vec;
endmodule

// File: doc/npem_multi_slot_ctrl.md
Name: npem_multi_slot_ctrl

Overview:
- Parametrised NPEM control/status engine for NUM_SLOTS downstream slots. Each slot has its own capability-masked Control and Status registers.
- Every accepted control write becomes a command to a single shared enclosure backend. A round-robin arbiter grants backend access.
- Completion or timeout sets per-slot Status bits; an aggregate interrupt is raised.
- Sits between the config-space register decoder and the enclosure management backend. It replaces the single-slot control register.

Parameters:
- NUM_SLOTS, 4, number of independent slots (1..16).
- REG_W, 32, register width; fixed field map below assumes 32.
- TIMEOUT_CYC, 1024, cycles to wait for backend done before declaring timeout (>=2).
- SLOT_W, $clog2(NUM_SLOTS) min 1, slot index width (derived, localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  one-cycle write strobe
- cfg_wr_sel  in  1  0=Control reg, 1=Status reg
- cfg_slot  in  SLOT_W  target slot for write/read
- cfg_wdata  in  REG_W  write data
- cfg_rd_ctrl  out  REG_W  Control readback of cfg_slot (combinational)
- cfg_rd_stat  out  REG_W  Status readback of cfg_slot (combinational)
- cfg_wr_busy_err  out  1  registered pulse: Control write dropped, slot busy
- cap  in  NUM_SLOTS*REG_W  per-slot capability vectors, slot i at [i*REG_W +: REG_W]
- cmd_valid  out  1  command to backend
- cmd_ready  in  1  backend accepts command
- cmd_slot  out  SLOT_W  slot of the command
- cmd_reset  out  1  command is an NPEM reset
- cmd_data  out  REG_W  masked control value
- cmd_done  in  1  one-cycle completion pulse
- cmd_done_slot  in  SLOT_W  slot being completed
- irq  out  1  level interrupt

Behaviour:
- Reset: all Control, Status and FSMs clear. cmd_valid=0, irq=0, cfg_wr_busy_err=0, arbiter pointer=0.
- Control field map:
  - bit0 enable, written always.
  - bit1 initiate-reset, write-only, reads 0.
  - bits[11:2] controls; each bit is written only if cap[slot][bit]=1, otherwise it reads 0.
  - bits[23:12] reserved, read 0.
  - bits[31:24] enclosure-specific; written only if cap[slot][31:24]!=0.
  - bit30 is also irq_en for the slot.
- Status field map, all RW1C:
  - bit0 command-completed.
  - bit1 timeout.
  - bit2 busy-drop.
  - Other bits read 0. A write to Status clears the bits written as 1.
- Per-slot FSM: IDLE -> REQ -> WAIT -> IDLE.
  - IDLE + Control write: update register next cycle, latch command (cmd_reset = wdata[1] & cap[1]), go to REQ.
  - REQ: request arbiter. When granted and cmd_ready, go to WAIT and load the timer with TIMEOUT_CYC.
  - WAIT: cmd_done with matching slot sets Status bit0 and returns to IDLE. Timer reaching 0 sets bit1 and bit0 and returns to IDLE.
  - On a reset command's completion or timeout, Control bits[11:0] of that slot clear to 0. bits[31:24] are kept.
- Control write while the slot is in REQ/WAIT:
  - Register is unchanged.
  - Status bit2 is set.
  - cfg_wr_busy_err pulses one cycle later.
- Arbiter: round-robin among slots in REQ.
  - cmd_valid, cmd_slot, cmd_data and cmd_reset are registered.
  - They are held stable while cmd_valid & !cmd_ready.
  - The pointer advances to grant+1 after each handshake.
  - At most one command is outstanding per slot. Several slots may be in WAIT at once.
- Latency: first cmd_valid appears 2 cycles after the write strobe, with no contention.
- cmd_done for a slot not in WAIT is ignored.
- Same-cycle cmd_done and timeout expiry: done wins, so bit1 stays 0.
- Same-cycle RW1C clear and set of the same bit: set wins.
- irq = OR over slots of (Status bit0 | bit1) & Control bit30.
- A write with cfg_slot >= NUM_SLOTS is ignored; readback returns 0.
- rst_n assertion mid-command aborts everything immediately. No done is expected afterwards.

Decomposition:
- Package npem_pkg holds:
  - slot_state_e enum (IDLE, REQ, WAIT).
  - Control bit-index constants: EN=0, RST=1, CTL_LO=2, CTL_HI=11, ES_LO=24, IRQEN=30.
  - Status bit constants: CC=0, TO=1, BUSY=2.
- Sub-module npem_slot_fsm: one instance per slot via generate. It holds Control/Status, the FSM and the timeout counter.
- The round-robin arbiter and command output register stay in the top.

Test Plan:
- Slot0, cap=0x0000_0FFD, write Control 0xFFFF_FFFF:
  - Readback is 0x0000_0FFD.
  - cmd_valid appears 2 cycles later with cmd_data=0x0000_0FFD and cmd_reset=0.
  - After cmd_done(slot0), Status=0x1.
  - Writing Status 0x1 then reads Status=0.
- Slot2, cap bit1=1, Control holds 0x0000_0005, write 0x0000_0002:
  - cmd_reset=1 is issued.
  - On done, slot2 Control reads 0x0000_0000 and Status bit0=1.
- Slot1 in WAIT, write Control 0x1:
  - Register is unchanged.
  - cfg_wr_busy_err pulses once.
  - Status bit2=1.
  - No new cmd_valid for slot1.
- Slots 0, 1 and 3 written in the same 3 cycles, cmd_ready held 0 for 5 cycles then 1:
  - Commands are presented in order 0, 1, 3.
  - Each command is held stable until its handshake.
- TIMEOUT_CYC=16, no cmd_done:
  - Exactly 16 cycles after the handshake, Status=0x3.
  - With Control bit30=1, irq rises.
  - A cmd_done arriving later is ignored.
- Assert rst_n while slot0 is in WAIT and cmd_valid is high for slot1:
  - All outputs return to 0 and all Status/Control read 0.
  - A subsequent write works normally.
